// File: rtl/l1_cache.sv
// l1_cache: two-way set-associative, write-back, write-allocate unified cache.
// 8 sets x 2 ways x 128-bit lines. CPU side uses 16-bit words with a byte mask;
// memory side moves whole lines.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   mem_address/read/write     CPU request (held until mem_resp)
//   mem_byte_enable, mem_wdata CPU write byte mask and data
//   mem_rdata, mem_resp        CPU read data and one-cycle completion pulse
//   pmem_address/read/write    line request to physical memory (held until pmem_resp)
//   pmem_wdata, pmem_rdata     victim line out / fill line in
//   pmem_resp                  physical memory completion pulse
module l1_cache (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned TagW    = 9;
  localparam int unsigned NumSets = 8;

  typedef enum logic [1:0] {StIdle, StWriteback, StFill} state_e;

  state_e state_q, state_d;

  // Per-way arrays; valid/dirty/lru are reset, tag/data are not.
  logic [NumSets-1:0] valid_q [2];
  logic [NumSets-1:0] valid_d [2];
  logic [NumSets-1:0] dirty_q [2];
  logic [NumSets-1:0] dirty_d [2];
  logic [NumSets-1:0] lru_q, lru_d;
  logic [TagW-1:0]    tag_q  [2][NumSets];
  logic [127:0]       data_q [2][NumSets];

  // Victim way and line address are captured at the miss so the writeback and
  // fill stay consistent even if the CPU drops its request.
  logic        victim_q, victim_d;
  logic [11:0] line_addr_q, line_addr_d;

  logic [TagW-1:0] req_tag;
  logic [2:0]      req_idx;
  logic [2:0]      word_sel;
  logic [2:0]      miss_idx;
  logic            req;
  logic            hit0, hit1, hit, hit_way;
  logic            victim_sel;
  logic [127:0]    hit_line, merged_line;

  logic            data_we, tag_we, wr_way;
  logic [2:0]      wr_idx;
  logic [127:0]    wr_line;

  logic unused_addr_bit;
  assign unused_addr_bit = mem_address[0];

  assign req_tag  = mem_address[15:7];
  assign req_idx  = mem_address[6:4];
  assign word_sel = mem_address[3:1];
  assign miss_idx = line_addr_q[2:0];
  assign req      = mem_read | mem_write;

  assign hit0     = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit1     = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_line = hit1 ? data_q[1][req_idx] : data_q[0][req_idx];

  // First invalid way (way0 preferred), otherwise the LRU way.
  always_comb begin
    if (!valid_q[0][req_idx])      victim_sel = 1'b0;
    else if (!valid_q[1][req_idx]) victim_sel = 1'b1;
    else                           victim_sel = lru_q[req_idx];
  end

  always_comb begin
    merged_line = hit_line;
    if (mem_byte_enable[0]) merged_line[{word_sel, 4'h0} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged_line[{word_sel, 4'h8} +: 8] = mem_wdata[15:8];
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req && !hit) begin
          state_d = (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx]) ?
                    StWriteback : StFill;
        end
      end
      StWriteback: if (pmem_resp) state_d = StFill;
      StFill:      if (pmem_resp) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    mem_rdata    = hit_line[{word_sel, 4'h0} +: 16];
    pmem_wdata   = data_q[victim_q][miss_idx];
    unique case (state_q)
      StIdle: mem_resp = req && hit;
      StWriteback: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[victim_q][miss_idx], miss_idx, 4'h0};
      end
      StFill: begin
        pmem_read    = 1'b1;
        pmem_address = {line_addr_q, 4'h0};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  always_comb begin
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    lru_d       = lru_q;
    victim_d    = victim_q;
    line_addr_d = line_addr_q;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    wr_way      = hit_way;
    wr_idx      = req_idx;
    wr_line     = merged_line;
    unique case (state_q)
      StIdle: begin
        if (req && hit) begin
          lru_d[req_idx] = ~hit_way;
          // Write wins when read and write are both asserted.
          if (mem_write) begin
            data_we                  = 1'b1;
            dirty_d[hit_way][req_idx] = 1'b1;
          end
        end else if (req) begin
          victim_d    = victim_sel;
          line_addr_d = mem_address[15:4];
        end
      end
      StWriteback: begin
        if (pmem_resp) dirty_d[victim_q][miss_idx] = 1'b0;
      end
      StFill: begin
        if (pmem_resp) begin
          data_we                      = 1'b1;
          tag_we                       = 1'b1;
          wr_way                       = victim_q;
          wr_idx                       = miss_idx;
          wr_line                      = pmem_rdata;
          valid_d[victim_q][miss_idx]  = 1'b1;
          dirty_d[victim_q][miss_idx]  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q[0]  <= '0;
      valid_q[1]  <= '0;
      dirty_q[0]  <= '0;
      dirty_q[1]  <= '0;
      lru_q       <= '0;
      victim_q    <= 1'b0;
      line_addr_q <= '0;
    end else begin
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      lru_q       <= lru_d;
      victim_q    <= victim_d;
      line_addr_q <= line_addr_d;
    end
  end

  // Arrays are not reset; writes are suppressed while reset is asserted so a
  // fill completing in the reset cycle leaves no trace.
  always_ff @(posedge clk) begin
    if (data_we && !reset) data_q[wr_way][wr_idx] <= wr_line;
    if (tag_we && !reset)  tag_q[wr_way][wr_idx]  <= line_addr_q[11:3];
  end

endmodule

// File: tb/tb_l1_cache.sv
// Directed self-checking bench for l1_cache with a behavioural line memory.
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int errors = 0;
  int checks = 0;

  l1_cache dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  // Physical memory model
  logic [127:0] mem [4096];
  int           mem_delay = 3;
  int           fill_count = 0, wb_count = 0;
  logic [15:0]  last_fill_addr, last_wb_addr;
  logic [127:0] last_wb_data;
  int           stable_err = 0, both_err = 0;

  initial begin
    int cnt;
    logic [15:0]  start_addr;
    logic [127:0] start_wdata;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    start_addr = '0;
    start_wdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (reset || !(pmem_read || pmem_write)) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 1) begin
          start_addr  = pmem_address;
          start_wdata = pmem_wdata;
        end else if (pmem_address !== start_addr ||
                     (pmem_write && pmem_wdata !== start_wdata)) begin
          stable_err++;
        end
        if (cnt >= mem_delay) begin
          pmem_resp = 1'b1;
          cnt = 0;
          if (pmem_write) begin
            mem[pmem_address[15:4]] = pmem_wdata;
            last_wb_addr = pmem_address;
            last_wb_data = pmem_wdata;
            wb_count++;
          end else begin
            pmem_rdata = mem[pmem_address[15:4]];
            last_fill_addr = pmem_address;
            fill_count++;
          end
        end
      end
    end
  end

  always @(posedge clk) if (pmem_read && pmem_write) both_err++;

  // Issue one CPU request; returns data seen with mem_resp and the cycle count.
  task automatic cpu_access(input logic [15:0] a, input logic rd, input logic wr,
                            input logic [1:0] be, input logic [15:0] wd,
                            output logic [15:0] rdata, output int cycles, output logic ok);
    @(negedge clk);
    mem_address = a; mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_wdata = wd;
    cycles = 0; ok = 1'b0; rdata = 'x;
    while (!ok && cycles < 200) begin
      #1;
      cycles++;
      if (mem_resp) begin
        ok = 1'b1;
        rdata = mem_rdata;
      end
      @(negedge clk);
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mem_resp: got %b want 0", mem_resp); end
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
    checks++; if (pmem_address !== 16'h0) begin errors++; $display("FAIL reset_pmem_address: got %h want 0000", pmem_address); end
  endtask

  task automatic test_cold_read();
    logic [15:0] d; int cyc; logic ok; int f0;
    mem_delay = 3;
    f0 = fill_count;
    cpu_access(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cold_resp: got %b want 1", ok); end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL cold_latency: got %0d want 5", cyc); end
    checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL cold_rdata: got %h want beef", d); end
    checks++; if (fill_count - f0 !== 1) begin errors++; $display("FAIL cold_fills: got %0d want 1", fill_count - f0); end
    checks++; if (last_fill_addr !== 16'h0010) begin errors++; $display("FAIL cold_fill_addr: got %h want 0010", last_fill_addr); end
    f0 = fill_count;
    cpu_access(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL hit_latency: got %0d want 1", cyc); end
    checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL hit_rdata: got %h want beef", d); end
    checks++; if (fill_count !== f0) begin errors++; $display("FAIL hit_no_pmem: got %0d want %0d", fill_count, f0); end
  endtask

  task automatic test_write_mask();
    logic [15:0] d; int cyc; logic ok;
    cpu_access(16'h0012, 1'b0, 1'b1, 2'b01, 16'h12AB, d, cyc, ok);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL wr_lo_latency: got %0d want 1", cyc); end
    cpu_access(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (d !== 16'hBEAB) begin errors++; $display("FAIL wr_lo_data: got %h want beab", d); end
    cpu_access(16'h0012, 1'b0, 1'b1, 2'b10, 16'h3400, d, cyc, ok);
    cpu_access(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (d !== 16'h34AB) begin errors++; $display("FAIL wr_hi_data: got %h want 34ab", d); end
  endtask

  task automatic test_lru_evict();
    logic [15:0] d; int cyc; logic ok; int w0;
    w0 = wb_count;
    cpu_access(16'h0092, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (d !== 16'hA0A1 || cyc !== 5) begin errors++; $display("FAIL fill_way1: got %h/%0d want a0a1/5", d, cyc); end
    cpu_access(16'h0012, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (d !== 16'h34AB || cyc !== 1) begin errors++; $display("FAIL way0_still_hit: got %h/%0d want 34ab/1", d, cyc); end
    cpu_access(16'h0112, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (d !== 16'hC0C1 || cyc !== 5) begin errors++; $display("FAIL evict_way1: got %h/%0d want c0c1/5", d, cyc); end
    checks++; if (wb_count !== w0) begin errors++; $display("FAIL clean_evict_wb: got %0d want %0d", wb_count, w0); end
    cpu_access(16'h0092, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (d !== 16'hA0A1 || cyc !== 8) begin errors++; $display("FAIL dirty_evict: got %h/%0d want a0a1/8", d, cyc); end
    checks++; if (wb_count - w0 !== 1) begin errors++; $display("FAIL dirty_wb_count: got %0d want 1", wb_count - w0); end
    checks++; if (last_wb_addr !== 16'h0010) begin errors++; $display("FAIL wb_addr: got %h want 0010", last_wb_addr); end
    checks++; if (last_wb_data[31:16] !== 16'h34AB) begin errors++; $display("FAIL wb_data: got %h want 34ab", last_wb_data[31:16]); end
    checks++; if (last_fill_addr !== 16'h0090) begin errors++; $display("FAIL refill_addr: got %h want 0090", last_fill_addr); end
    cpu_access(16'h0112, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (d !== 16'hC0C1 || cyc !== 1) begin errors++; $display("FAIL way1_kept: got %h/%0d want c0c1/1", d, cyc); end
  endtask

  task automatic test_rw_both();
    logic [15:0] d; int cyc; logic ok;
    cpu_access(16'h0092, 1'b1, 1'b1, 2'b11, 16'h5A5A, d, cyc, ok);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL rw_latency: got %0d want 1", cyc); end
    cpu_access(16'h0092, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL rw_data: got %h want 5a5a", d); end
  endtask

  task automatic test_reset_in_fill();
    logic [15:0] d; int cyc; logic ok; int f0;
    mem_delay = 10;
    @(negedge clk);
    mem_address = 16'h0202; mem_read = 1'b1; mem_write = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL rif_pmem_read: got %b want 1", pmem_read); end
    @(negedge clk);
    reset = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL rif_drop: got %b want 0", pmem_read); end
    checks++; if (pmem_address !== 16'h0) begin errors++; $display("FAIL rif_addr: got %h want 0000", pmem_address); end
    reset = 1'b0;
    mem_delay = 3;
    f0 = fill_count;
    cpu_access(16'h0202, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (cyc !== 5 || d !== 16'h5555) begin errors++; $display("FAIL rif_remiss: got %0d/%h want 5/5555", cyc, d); end
    checks++; if (fill_count - f0 !== 1) begin errors++; $display("FAIL rif_fills: got %0d want 1", fill_count - f0); end
  endtask

  task automatic test_slow_memory();
    logic [15:0] d; int cyc; logic ok;
    cpu_access(16'h0202, 1'b0, 1'b1, 2'b11, 16'h7777, d, cyc, ok);
    cpu_access(16'h0282, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (cyc !== 5 || d !== 16'h2828) begin errors++; $display("FAIL slow_setup: got %0d/%h want 5/2828", cyc, d); end
    mem_delay = 20;
    stable_err = 0;
    cpu_access(16'h0302, 1'b1, 1'b0, 2'b00, 16'h0, d, cyc, ok);
    checks++; if (cyc !== 42) begin errors++; $display("FAIL slow_latency: got %0d want 42", cyc); end
    checks++; if (d !== 16'h3C3C) begin errors++; $display("FAIL slow_rdata: got %h want 3c3c", d); end
    checks++; if (stable_err !== 0) begin errors++; $display("FAIL slow_stable: got %0d unstable cycles want 0", stable_err); end
    checks++; if (last_wb_addr !== 16'h0200 || last_wb_data[31:16] !== 16'h7777) begin
      errors++; $display("FAIL slow_wb: got %h/%h want 0200/7777", last_wb_addr, last_wb_data[31:16]);
    end
    mem_delay = 3;
  endtask

  initial begin
    reset = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h001] = 128'h7777_6666_5555_4444_3333_2222_BEEF_1111;
    mem[12'h009] = 128'h0000_0000_0000_0000_0000_0000_A0A1_0000;
    mem[12'h011] = 128'h0000_0000_0000_0000_0000_0000_C0C1_0000;
    mem[12'h020] = 128'h0000_0000_0000_0000_0000_0000_5555_0000;
    mem[12'h028] = 128'h0000_0000_0000_0000_0000_0000_2828_0000;
    mem[12'h030] = 128'h0000_0000_0000_0000_0000_0000_3C3C_0000;
    test_reset();
    test_cold_read();
    test_write_mask();
    test_lru_evict();
    test_rw_both();
    test_reset_in_fill();
    test_slow_memory();
    checks++; if (both_err !== 0) begin errors++; $display("FAIL rd_wr_exclusive: got %0d overlaps want 0", both_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_cache.md
# l1_cache

Two-way set-associative, write-back, write-allocate unified cache between the LC-3b CPU memory port and physical memory. Geometry: 8 sets × 2 ways × 16-byte (128-bit) lines, giving 256 bytes total. The CPU side carries 16-bit words with a 2-bit byte mask. The memory side carries whole 128-bit lines. Datapath and controller live in one block, and all field widths match the lc3b_types package (lc3b_tag, lc3b_index, lc3b_offset, lc3b_data, lc3b_mem_wmask).

## Interface
- No parameters; geometry is fixed by lc3b_types.
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- mem_address  in  16  CPU byte address: tag=[15:7], index=[6:4], offset=[3:0]
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  2  bit0 writes low byte, bit1 writes high byte
- mem_wdata  in  16  CPU write word
- mem_rdata  out  16  word selected by offset[3:1] from the hit line
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  16  line address, bits [3:0] always 0
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_wdata  out  128  victim line
- pmem_rdata  in  128  fill line
- pmem_resp  in  1  physical memory completion pulse

## Operation
- **Per-set state:** valid[2], dirty[2], tag[2] (9 bits each), and one LRU bit. The LRU bit names the least-recently-used way.
- **Reset:** clears all valid, dirty and LRU bits and enters IDLE. Data and tag arrays are not reset.
- **Hit:** a way in the selected set is valid and its tag equals mem_address[15:7].
- **Victim selection:**
  - First invalid way, with way0 preferred.
  - Otherwise the way named by LRU.
- **FSM states:**
  - **IDLE:**
    - Read hit: assert mem_resp. Drive mem_rdata = line[16·offset[3:1] +: 16] of the hit way.
    - Write hit: assert mem_resp. Merge enabled bytes into the hit line at the clock edge and set dirty.
    - Any hit: at the edge, LRU becomes the other way.
    - Miss: go to WRITEBACK if the victim is valid and dirty, else go to FILL.
  - **WRITEBACK:**
    - pmem_write=1, pmem_address={victim tag, index, 4'h0}, pmem_wdata=victim line.
    - On pmem_resp: clear the victim's dirty bit and go to FILL.
  - **FILL:**
    - pmem_read=1, pmem_address={mem_address[15:4], 4'h0}.
    - On pmem_resp: at the edge, write pmem_rdata into the victim way, write the tag, set valid=1 and dirty=0, then go to IDLE.
    - The request is then serviced in IDLE as a hit.
- **Simultaneous requests:** if mem_read and mem_write are both high, the write wins. A write with mem_byte_enable=00 responds, leaves data unchanged and still sets dirty.
- **Dropped request:** if the CPU deasserts its request during WRITEBACK/FILL, the transaction still completes and the cache returns to IDLE with no mem_resp.
- **Address stability:** mem_address, mem_wdata and mem_byte_enable must be stable from request assertion until mem_resp.

## Timing
- **Output defaults:** every output is 0 except mem_rdata (hit-way word, don't-care on miss) and pmem_wdata (don't-care outside WRITEBACK).
- **Reset values:** mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0.
- **Hit latency:** mem_resp is combinational in the same cycle the request is seen in IDLE.
  - A request held high after mem_resp is treated as a new request.
  - The CPU must drop or change its request the cycle after mem_resp.
- **Clean-miss latency:** 1 IDLE cycle + N FILL cycles (pmem_resp on the Nth) + 1 IDLE hit cycle.
- **Dirty-miss latency:** adds M WRITEBACK cycles.
- **pmem_read/pmem_write:**
  - Registered state decodes, never both high.
  - Held constant with a stable address until pmem_resp.
  - pmem_resp outside WRITEBACK/FILL is ignored.
- **Reset mid-miss:** at the edge the state is IDLE and pmem_read/pmem_write drop the following cycle. A fill in progress is discarded and no valid bit is set.

## Test plan
- **Cold read miss:** after reset, mem_read @0x0012, pmem returns line with word1=0xBEEF after 3 cycles -> pmem_read with pmem_address=0x0010, then mem_rdata=0xBEEF with a single mem_resp. Repeat the read -> same-cycle hit, no pmem activity.
- **Byte-masked write hit:** write 0x12AB with mask 01 to 0x0012, then read 0x0012 -> 0xBEAB. Mask 10 with 0x3400 -> 0x34AB.
- **LRU eviction and writeback:**
  - Setup: fill 0x0010 (way0, dirty by the write above) and 0x0090 (way1), then read 0x0010 so LRU=way1.
  - Read 0x0110 -> evicts way1 with no writeback.
  - Read 0x0090 -> evicts way0 with a writeback of pmem_address=0x0010 whose wdata word1=0x34AB, then a fill of 0x0090.
- **Read and write both high:** assert mem_read and mem_write together on a hit -> write semantics, line data updated.
- **Reset in FILL:** assert reset while pmem_read=1 -> pmem_read=0 next cycle. The same address then misses again.
- **Slow memory:** pmem_resp delayed 20 cycles -> pmem_address/pmem_wdata stable throughout and mem_resp never early.
